vend_core_multi: RTL and testbench
==================================

// Module: vend_core_multi
// PURPOSE
//  Parametrised next-generation vending core. It accumulates credit, checks price and stock
//  for NUM_ITEMS items, and vends. Change is paid as discrete coins (5/2/1, greedy), and an
//  idle session refunds itself after a timeout. Sits between coin_handler/debounce and
//  display_driver/sound_module in the top level. It replaces the separate fsm_controller +
//  inventory pair and keeps a per-item stock array.
// PARAMETERS
//  NUM_ITEMS   4     number of selectable items (>=2)
//  ITEM_W      2     item select width, = $clog2(NUM_ITEMS)
//  CREDIT_W    8     credit/price/coin width, unsigned
//  MAX_CREDIT  99    credit ceiling; a coin that would exceed it is rejected
//  STOCK_W     4     per-item stock counter width
//  MAX_STOCK   9     restock fill level (< 2**STOCK_W)
//  TIMEOUT_CYC 1000  idle cycles in CREDIT before auto-refund
//  ERR_CYC     16    cycles ERROR is held
//  PAYOUT_GAP  4     cycles between payout coins (>=2)
// PORTS
//  clk           in   1                    system clock
//  rst           in   1                    async active-high reset
//  coin_pulse    in   1                    one-cycle coin strobe
//  coin_value    in   CREDIT_W             coin value, valid with coin_pulse
//  purchase      in   1                    debounced level; rising edge detected internally
//  item_sel      in   ITEM_W               selected item; values >= NUM_ITEMS are invalid
//  restock       in   1                    level; refills all items while in IDLE
//  price_flat    in   NUM_ITEMS*CREDIT_W   item i price at [i*CREDIT_W +: CREDIT_W]
//  credit        out  CREDIT_W             current credit
//  stock_level   out  STOCK_W              stock of item_sel (0 if invalid)
//  vend_pulse    out  1                    one-cycle vend strobe
//  vend_item     out  ITEM_W               item vended, valid with vend_pulse
//  payout_pulse  out  1                    one-cycle coin-out strobe
//  payout_value  out  CREDIT_W             5, 2 or 1; valid with payout_pulse
//  coin_reject   out  1                    one-cycle: coin not accepted
//  error_flag    out  1                    high throughout ERROR
//  state         out  3                    encoded FSM state, for display_driver
// BEHAVIOUR
//  Reset: state=IDLE; credit=0; all stocks=MAX_STOCK; all pulses, error_flag and timers = 0.
//  Registered outputs. Reset mid-payout aborts payout; credit is lost.
//  States: IDLE, CREDIT, VEND, CHANGE, ERROR.
//   IDLE: an accepted coin sets credit=coin_value -> CREDIT. Restock is honoured only here.
//   CREDIT: coin adds to credit. Any coin_pulse or purchase edge clears the timeout timer.
//    purchase edge: invalid item or stock==0 or credit<price -> ERROR; else -> VEND.
//    Timer reaching TIMEOUT_CYC -> CHANGE with the full credit.
//   VEND: exactly 1 cycle. vend_pulse=1, vend_item=item_sel; stock--; credit-=price.
//    Then -> CHANGE if credit>0, else -> IDLE.
//   CHANGE: greedy payout, one coin per PAYOUT_GAP cycles, first coin on the cycle after
//    entry. Each coin subtracts from credit. credit==0 -> IDLE.
//   ERROR: error_flag=1 for ERR_CYC cycles, credit retained, then -> CREDIT (IDLE if credit 0).
//  Coin acceptance: only in IDLE/CREDIT and only if credit+coin_value <= MAX_CREDIT.
//   Compute the sum at CREDIT_W+1 bits. coin_value==0 is rejected. A rejected coin gives
//   coin_reject=1 the next cycle and credit is unchanged.
//  Simultaneous coin_pulse and purchase edge in CREDIT: the coin is applied; the purchase is
//   evaluated against the post-coin credit on the next cycle (edge latched as pending).
//  Purchase edges outside CREDIT are dropped (not latched). Restock outside IDLE is ignored.
//  Stock never underflows; vend is only entered with stock>0.
//  Simultaneous restock and coin in IDLE: restock applies and the coin is also accepted.
// STRUCTURE
//  Package vend_pkg: state enum/encoding, COIN5/COIN2/COIN1 constants.
//  Sub-module change_dispenser: greedy coin selection + PAYOUT_GAP timer. Handshake:
//   start/amount in; coin pulse/value/done out.
//  Stock array and FSM live in the top module; no other hierarchy.
// TESTING
//  1 coins 5,5 (credit 10), item 1 price 7, purchase -> vend_pulse item 1; payouts 2 then 1,
//    4 cycles apart; stock[1] 9->8; credit 0; IDLE.
//  2 credit 98, coin 2 -> coin_reject, credit stays 98; coin 1 -> credit 99.
//  3 stock[2] driven to 0 via 9 vends, then purchase item 2 -> ERROR 16 cycles, credit kept,
//    return to CREDIT.
//  4 coin 5, no activity 1000 cycles -> CHANGE, single payout 5, IDLE.
//  5 coin_pulse and purchase edge in the same cycle with credit 5 + coin 2, price 7 ->
//    vend succeeds next cycle.
//  6 assert rst during CHANGE with credit 8 -> immediate IDLE, credit 0, no further payouts;
//    restock in CREDIT ignored.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending core: FSM state encoding and payout coin values.
package vend_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_CREDIT = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  localparam int unsigned COIN5 = 5;
  localparam int unsigned COIN2 = 2;
  localparam int unsigned COIN1 = 1;

endpackage

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays an amount as 5/2/1 coins, one coin every PAYOUT_GAP cycles.
// Ports: start/amount load a new payout (first coin on the following cycle);
//        coin_pulse/coin_value strobe each coin; done pulses with the final coin.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned PAYOUT_GAP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CREDIT_W-1:0] amount,
  output logic                coin_pulse,
  output logic [CREDIT_W-1:0] coin_value,
  output logic                done
);

  localparam int unsigned GAP_W = (PAYOUT_GAP > 2) ? $clog2(PAYOUT_GAP) : 1;

  logic                busy_q, busy_d;
  logic [CREDIT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                coin_pulse_q, coin_pulse_d;
  logic [CREDIT_W-1:0] coin_value_q, coin_value_d;
  logic                done_q, done_d;
  logic [CREDIT_W-1:0] coin_c;

  // Largest coin that fits the remaining amount
  always_comb begin
    coin_c = CREDIT_W'(COIN1);
    if (rem_q >= CREDIT_W'(COIN5)) begin
      coin_c = CREDIT_W'(COIN5);
    end else if (rem_q >= CREDIT_W'(COIN2)) begin
      coin_c = CREDIT_W'(COIN2);
    end
  end

  // Payout sequencing; gap counter at zero means a coin may go out this cycle
  always_comb begin
    busy_d       = busy_q;
    rem_d        = rem_q;
    gap_d        = gap_q;
    coin_pulse_d = 1'b0;
    coin_value_d = coin_value_q;
    done_d       = 1'b0;
    if (start) begin
      busy_d = 1'b1;
      rem_d  = amount;
      gap_d  = '0;
    end else if (busy_q) begin
      if (rem_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else if (gap_q == '0) begin
        coin_pulse_d = 1'b1;
        coin_value_d = coin_c;
        rem_d        = rem_q - coin_c;
        gap_d        = GAP_W'(PAYOUT_GAP - 1);
        if (rem_q == coin_c) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        gap_d = gap_q - GAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= 1'b0;
      rem_q        <= '0;
      gap_q        <= '0;
      coin_pulse_q <= 1'b0;
      coin_value_q <= '0;
      done_q       <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      rem_q        <= rem_d;
      gap_q        <= gap_d;
      coin_pulse_q <= coin_pulse_d;
      coin_value_q <= coin_value_d;
      done_q       <= done_d;
    end
  end

  assign coin_pulse = coin_pulse_q;
  assign coin_value = coin_value_q;
  assign done       = done_q;

endmodule

// File: rtl/vend_core_multi.sv
// Multi-item vending core: credit accumulation, price/stock check, vend, greedy change,
// idle timeout refund and timed error indication.
// Ports: coin_pulse/coin_value and purchase/item_sel in; restock level refills in IDLE;
//        price_flat packs per-item prices. Outputs credit, stock_level (selected item),
//        vend/payout/reject strobes, error_flag and the encoded state.
module vend_core_multi
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS   = 4,
  parameter int unsigned ITEM_W      = 2,
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned MAX_CREDIT  = 99,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned MAX_STOCK   = 9,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned ERR_CYC     = 16,
  parameter int unsigned PAYOUT_GAP  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin_pulse,
  input  logic [CREDIT_W-1:0]           coin_value,
  input  logic                          purchase,
  input  logic [ITEM_W-1:0]             item_sel,
  input  logic                          restock,
  input  logic [NUM_ITEMS*CREDIT_W-1:0] price_flat,
  output logic [CREDIT_W-1:0]           credit,
  output logic [STOCK_W-1:0]            stock_level,
  output logic                          vend_pulse,
  output logic [ITEM_W-1:0]             vend_item,
  output logic                          payout_pulse,
  output logic [CREDIT_W-1:0]           payout_value,
  output logic                          coin_reject,
  output logic                          error_flag,
  output logic [STATE_W-1:0]            state
);

  localparam int unsigned TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned ERR_W = (ERR_CYC > 2) ? $clog2(ERR_CYC) : 1;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_level_q, stock_level_d;
  logic                purchase_q, purchase_d;
  logic                pend_q, pend_d;
  logic [ITEM_W-1:0]   sel_q, sel_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic                vend_pulse_q, vend_pulse_d;
  logic [ITEM_W-1:0]   vend_item_q, vend_item_d;
  logic                coin_reject_q, coin_reject_d;
  logic                error_flag_q, error_flag_d;

  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok, pur_edge, sel_valid;
  logic [CREDIT_W-1:0] sel_price, vend_price, vend_rem;
  logic [STOCK_W-1:0]  sel_stock;
  logic                disp_start;
  logic [CREDIT_W-1:0] disp_amount;
  logic                disp_coin;
  logic [CREDIT_W-1:0] disp_value;
  logic                disp_done;

  // Coin acceptance and selection lookups
  always_comb begin
    coin_sum   = {1'b0, credit_q} + {1'b0, coin_value};
    coin_ok    = coin_pulse && (coin_value != '0) &&
                 ((state_q == ST_IDLE) || (state_q == ST_CREDIT)) &&
                 (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    pur_edge   = purchase && !purchase_q;
    sel_valid  = 32'(item_sel) < NUM_ITEMS;
    sel_price  = price_flat[32'(item_sel)*CREDIT_W +: CREDIT_W];
    sel_stock  = sel_valid ? stock_q[item_sel] : '0;
    vend_price = price_flat[32'(sel_q)*CREDIT_W +: CREDIT_W];
    vend_rem   = credit_q - vend_price;
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    stock_d       = stock_q;
    purchase_d    = purchase;
    pend_d        = pend_q;
    sel_d         = sel_q;
    timer_d       = '0;
    err_cnt_d     = '0;
    vend_pulse_d  = 1'b0;
    vend_item_d   = vend_item_q;
    coin_reject_d = coin_pulse && !coin_ok;
    error_flag_d  = 1'b0;
    disp_start    = 1'b0;
    disp_amount   = credit_q;

    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (restock) begin
          for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = STOCK_W'(MAX_STOCK);
          end
        end
        if (coin_ok) begin
          credit_d = coin_value;
          state_d  = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        timer_d = (coin_pulse || pur_edge) ? '0 : timer_q + TMR_W'(1);
        if (coin_ok) begin
          // A purchase edge alongside an accepted coin is judged next cycle
          credit_d = coin_sum[CREDIT_W-1:0];
          if (pur_edge) pend_d = 1'b1;
        end else if (pur_edge || pend_q) begin
          pend_d = 1'b0;
          sel_d  = item_sel;
          if (!sel_valid || (sel_stock == '0) || (credit_q < sel_price)) begin
            state_d      = ST_ERROR;
            error_flag_d = 1'b1;
          end else begin
            state_d = ST_VEND;
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          state_d    = ST_CHANGE;
          disp_start = 1'b1;
        end
      end
      ST_VEND: begin
        vend_pulse_d     = 1'b1;
        vend_item_d      = sel_q;
        stock_d[sel_q]   = stock_q[sel_q] - STOCK_W'(1);
        credit_d         = vend_rem;
        if (vend_rem != '0) begin
          state_d     = ST_CHANGE;
          disp_start  = 1'b1;
          disp_amount = vend_rem;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (disp_coin) credit_d = credit_q - disp_value;
        if (disp_done) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (err_cnt_q == ERR_W'(ERR_CYC - 1)) begin
          state_d = (credit_q != '0) ? ST_CREDIT : ST_IDLE;
        end else begin
          err_cnt_d    = err_cnt_q + ERR_W'(1);
          error_flag_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    stock_level_d = sel_valid ? stock_d[item_sel] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= STOCK_W'(MAX_STOCK);
      end
      stock_level_q <= STOCK_W'(MAX_STOCK);
      purchase_q    <= 1'b0;
      pend_q        <= 1'b0;
      sel_q         <= '0;
      timer_q       <= '0;
      err_cnt_q     <= '0;
      vend_pulse_q  <= 1'b0;
      vend_item_q   <= '0;
      coin_reject_q <= 1'b0;
      error_flag_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      stock_q       <= stock_d;
      stock_level_q <= stock_level_d;
      purchase_q    <= purchase_d;
      pend_q        <= pend_d;
      sel_q         <= sel_d;
      timer_q       <= timer_d;
      err_cnt_q     <= err_cnt_d;
      vend_pulse_q  <= vend_pulse_d;
      vend_item_q   <= vend_item_d;
      coin_reject_q <= coin_reject_d;
      error_flag_q  <= error_flag_d;
    end
  end

  change_dispenser #(
    .CREDIT_W  (CREDIT_W),
    .PAYOUT_GAP(PAYOUT_GAP)
  ) u_change (
    .clk       (clk),
    .rst       (rst),
    .start     (disp_start),
    .amount    (disp_amount),
    .coin_pulse(disp_coin),
    .coin_value(disp_value),
    .done      (disp_done)
  );

  assign credit       = credit_q;
  assign stock_level  = stock_level_q;
  assign vend_pulse   = vend_pulse_q;
  assign vend_item    = vend_item_q;
  assign payout_pulse = disp_coin;
  assign payout_value = disp_value;
  assign coin_reject  = coin_reject_q;
  assign error_flag   = error_flag_q;
  assign state        = state_q;

endmodule

// File: tb/tb_vend_core_multi.sv
// Directed bench for vend_core_multi: hand-computed expectations checked with immediate assertions.
module tb_vend_core_multi;

  localparam int unsigned NI = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CREDIT = 3'd1;
  localparam logic [2:0] S_VEND   = 3'd2;
  localparam logic [2:0] S_CHANGE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic             clk = 1'b0;
  logic             rst;
  logic             coin_pulse;
  logic [CW-1:0]    coin_value;
  logic             purchase;
  logic [IW-1:0]    item_sel;
  logic             restock;
  logic [NI*CW-1:0] price_flat;
  logic [CW-1:0]    credit;
  logic [SW-1:0]    stock_level;
  logic             vend_pulse;
  logic [IW-1:0]    vend_item;
  logic             payout_pulse;
  logic [CW-1:0]    payout_value;
  logic             coin_reject;
  logic             error_flag;
  logic [2:0]       state;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  vend_core_multi dut (
    .clk         (clk),
    .rst         (rst),
    .coin_pulse  (coin_pulse),
    .coin_value  (coin_value),
    .purchase    (purchase),
    .item_sel    (item_sel),
    .restock     (restock),
    .price_flat  (price_flat),
    .credit      (credit),
    .stock_level (stock_level),
    .vend_pulse  (vend_pulse),
    .vend_item   (vend_item),
    .payout_pulse(payout_pulse),
    .payout_value(payout_value),
    .coin_reject (coin_reject),
    .error_flag  (error_flag),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int unsigned v);
    coin_pulse = 1'b1;
    coin_value = CW'(v);
    tick();
    coin_pulse = 1'b0;
  endtask

  task automatic press(input int unsigned item);
    item_sel = IW'(item);
    purchase = 1'b1;
    tick();
    purchase = 1'b0;
  endtask

  initial begin
    int unsigned cnt;
    int unsigned sum;

    rst        = 1'b1;
    coin_pulse = 1'b0;
    coin_value = '0;
    purchase   = 1'b0;
    item_sel   = 2'd1;
    restock    = 1'b0;
    // prices: item0=3, item1=7, item2=4, item3=10
    price_flat = {8'd10, 8'd4, 8'd7, 8'd3};
    tick();
    tick();
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_credit", 32'(credit), 0);
    chk("rst_stock", 32'(stock_level), 9);
    chk("rst_error", 32'(error_flag), 0);
    chk("rst_payout", 32'(payout_pulse), 0);
    rst = 1'b0;
    tick();

    // 1: 5+5, buy item 1 (price 7), change 2 then 1
    coin(5);
    chk("t1_credit5", 32'(credit), 5);
    chk("t1_state_credit", 32'(state), 32'(S_CREDIT));
    coin(5);
    chk("t1_credit10", 32'(credit), 10);
    press(1);
    chk("t1_state_vend", 32'(state), 32'(S_VEND));
    tick();
    chk("t1_vend_pulse", 32'(vend_pulse), 1);
    chk("t1_vend_item", 32'(vend_item), 1);
    chk("t1_credit3", 32'(credit), 3);
    chk("t1_stock8", 32'(stock_level), 8);
    chk("t1_state_change", 32'(state), 32'(S_CHANGE));
    tick();
    chk("t1_pay1_pulse", 32'(payout_pulse), 1);
    chk("t1_pay1_value", 32'(payout_value), 2);
    tick();
    chk("t1_credit1", 32'(credit), 1);
    tick();
    tick();
    chk("t1_gap_quiet", 32'(payout_pulse), 0);
    tick();
    chk("t1_pay2_pulse", 32'(payout_pulse), 1);
    chk("t1_pay2_value", 32'(payout_value), 1);
    tick();
    chk("t1_credit0", 32'(credit), 0);
    chk("t1_state_idle", 32'(state), 32'(S_IDLE));

    // 2: credit ceiling and zero coin, then buy item 3 and drain 89 of change
    coin(50);
    coin(48);
    chk("t2_credit98", 32'(credit), 98);
    coin(2);
    chk("t2_reject", 32'(coin_reject), 1);
    chk("t2_credit_kept", 32'(credit), 98);
    coin(0);
    chk("t2_reject_zero", 32'(coin_reject), 1);
    tick();
    chk("t2_reject_clear", 32'(coin_reject), 0);
    coin(1);
    chk("t2_credit99", 32'(credit), 99);
    chk("t2_no_reject", 32'(coin_reject), 0);
    press(3);
    tick();
    chk("t2_vend_item", 32'(vend_item), 3);
    chk("t2_credit89", 32'(credit), 89);
    cnt = 0;
    sum = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (payout_pulse) begin
        cnt++;
        sum += int'(payout_value);
      end
      if (state == S_IDLE) break;
    end
    chk("t2_payout_sum", sum, 89);
    chk("t2_payout_coins", cnt, 19);
    chk("t2_end_idle", 32'(state), 32'(S_IDLE));
    chk("t2_end_credit", 32'(credit), 0);

    // 3: empty item 2, then an attempt raises ERROR for 16 cycles
    for (int i = 0; i < 9; i++) begin
      coin(4);
      press(2);
      tick();
      chk("t3_vend", 32'({vend_pulse, state}), 32'({1'b1, S_IDLE}));
    end
    chk("t3_stock0", 32'(stock_level), 0);
    coin(5);
    press(2);
    chk("t3_error_flag", 32'(error_flag), 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (state != S_ERROR || !error_flag) break;
      cnt++;
      tick();
    end
    chk("t3_error_cycles", cnt, 16);
    chk("t3_back_credit", 32'(state), 32'(S_CREDIT));
    chk("t3_credit_kept", 32'(credit), 5);
    chk("t3_error_clear", 32'(error_flag), 0);

    // 5: coin and purchase edge together; purchase judged on post-coin credit
    coin_pulse = 1'b1;
    coin_value = 8'd2;
    item_sel   = 2'd1;
    purchase   = 1'b1;
    tick();
    coin_pulse = 1'b0;
    purchase   = 1'b0;
    chk("t5_credit7", 32'(credit), 7);
    chk("t5_still_credit", 32'(state), 32'(S_CREDIT));
    tick();
    chk("t5_state_vend", 32'(state), 32'(S_VEND));
    tick();
    chk("t5_vend", 32'({vend_pulse, vend_item}), 32'({1'b1, 2'd1}));
    chk("t5_credit0", 32'(credit), 0);
    chk("t5_idle", 32'(state), 32'(S_IDLE));

    // 4: idle timeout refunds a single 5
    coin(5);
    cnt = 0;
    while (cnt < 1100 && !payout_pulse) begin
      tick();
      cnt++;
    end
    chk("t4_timeout_cycles", cnt, 1001);
    chk("t4_payout_value", 32'(payout_value), 5);
    chk("t4_state_change", 32'(state), 32'(S_CHANGE));
    tick();
    chk("t4_idle", 32'(state), 32'(S_IDLE));
    chk("t4_credit0", 32'(credit), 0);
    chk("t4_single_payout", 32'(payout_pulse), 0);

    // 6: restock ignored in CREDIT; reset during CHANGE aborts payout
    item_sel = 2'd2;
    coin(5);
    restock = 1'b1;
    tick();
    restock = 1'b0;
    chk("t6_restock_ignored", 32'(stock_level), 0);
    coin(3);
    coin(3);
    press(0);
    tick();
    chk("t6_credit8", 32'(credit), 8);
    chk("t6_state_change", 32'(state), 32'(S_CHANGE));
    tick();
    chk("t6_first_payout", 32'({payout_pulse, payout_value}), 32'({1'b1, 8'd5}));
    rst = 1'b1;
    #1;
    chk("t6_rst_state", 32'(state), 32'(S_IDLE));
    chk("t6_rst_credit", 32'(credit), 0);
    chk("t6_rst_payout", 32'(payout_pulse), 0);
    tick();
    rst = 1'b0;
    item_sel = 2'd2;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (payout_pulse) cnt++;
    end
    chk("t6_no_more_payout", cnt, 0);
    chk("t6_stock_reset", 32'(stock_level), 9);

    // Restock together with a coin in IDLE: both take effect
    coin(4);
    press(2);
    tick();
    chk("t7_stock8", 32'(stock_level), 8);
    restock    = 1'b1;
    coin_pulse = 1'b1;
    coin_value = 8'd3;
    tick();
    restock    = 1'b0;
    coin_pulse = 1'b0;
    chk("t7_restock", 32'(stock_level), 9);
    chk("t7_credit3", 32'(credit), 3);
    chk("t7_state_credit", 32'(state), 32'(S_CREDIT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
